// File: rtl/mux8to1_stream_arb.sv
// 8-to-1 valid/ready stream merge with round-robin arbitration and optional
// packet locking. Output channel is fully registered; each beat carries the
// number of the channel it came from.
module mux8to1_stream_arb #(
    parameter int unsigned WIDTH   = 8,
    parameter bit          LOCK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_last,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_last,
    input  logic               out_ready
);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       lock_ch_q, lock_ch_d;

    logic             load_en;
    logic             grant_vld;
    logic [2:0]       grant;
    logic [2:0]       scan_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // Output register can take a new beat when empty or when its beat leaves.
    assign load_en = ~out_valid | out_ready;

    // Grant selection: lock owner only while locked, else first requester from rr_ptr.
    always_comb begin
        grant     = rr_ptr_q;
        grant_vld = 1'b0;
        scan_idx  = rr_ptr_q;
        if (state_q == StLocked) begin
            grant     = lock_ch_q;
            grant_vld = in_valid[lock_ch_q];
        end else begin
            // Descending scan so the requester closest to rr_ptr is written last and wins.
            for (int i = 7; i >= 0; i--) begin
                scan_idx = rr_ptr_q + 3'(i);
                if (in_valid[scan_idx]) begin
                    grant     = scan_idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Accept strobe back to the granted source; forced low while in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_vld) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign accept = |in_ready;

    // Data and end-of-packet flag of the granted channel.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (grant == 3'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
        sel_last = in_last[grant];
    end

    // Arbitration FSM next state: pointer advances past a channel once its packet ends.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_ch_d = lock_ch_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (sel_last || !LOCK_EN) begin
                        rr_ptr_d = grant + 3'd1;
                    end else begin
                        lock_ch_d = grant;
                        state_d   = StLocked;
                    end
                end
            end
            StLocked: begin
                if (accept && sel_last) begin
                    rr_ptr_d = lock_ch_q + 3'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Output stage: load on accept, empty on a free slot with no accept, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= sel_data;
                out_sel  <= grant;
                out_last <= sel_last;
            end
        end
    end

endmodule
